// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register carrying a control and a data bundle over valid/ready.
// REG_READY=1 adds a one-entry skid so in_ready comes straight from a flop.
module pipe_stage_skid #(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 5,
    parameter int REG_READY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_e;
    logic   fire_in, fire_out;
    logic   ld_main_in, ld_main_skid, ld_skid;

    assign in_e      = '{ctrl: in_ctrl, data: in_data};
    assign out_valid = (state != EMPTY);
    assign out_ctrl  = out_valid ? main_q.ctrl : '0;
    assign out_data  = main_q.data;
    assign occupancy = state;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = out_valid & out_ready;

    generate
        if (REG_READY != 0) begin : g_reg_ready
            assign in_ready = (state != FULL);
        end else begin : g_comb_ready
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (fire_in) begin
                        state_nxt  = BUSY;
                        ld_main_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (fire_in && fire_out) begin
                        ld_main_in = 1'b1;
                    end else if (fire_in && REG_READY != 0) begin
                        state_nxt = FULL;
                        ld_skid   = 1'b1;
                    end else if (fire_out) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (fire_out) begin
                        state_nxt    = BUSY;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)        main_q <= in_e;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid)           skid_q <= in_e;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: DUT a uses the skid buffer, DUT b the combinational-ready variant.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [4:0]  in_ctrl;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [4:0]  a_out_ctrl, b_out_ctrl;
    logic [31:0] a_out_data, b_out_data;
    logic [1:0]  a_occ, b_occ;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(5), .REG_READY(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(5), .REG_READY(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occupancy(b_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_ctrl = 5'h1F; in_data = 32'h55;
        tick();
        tick();
        n_assert += 5;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
        if (a_out_ctrl !== 5'h0) begin n_fail++; $display("FAIL reset_out_ctrl got %0h want 0", a_out_ctrl); end
        if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", a_out_data); end
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", a_occ); end
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
        in_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i); in_ctrl = 5'(i);
            #1;
            n_assert++;
            if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, a_in_ready); end
            tick();
            n_assert += 4;
            if (a_out_data !== 32'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got %0h want %0h", i, a_out_data, i); end
            if (a_out_ctrl !== 5'(i)) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %0h want %0h", i, a_out_ctrl, i); end
            if (a_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want 1", i, a_occ); end
            if (b_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ_b[%0d] got %0d want 1", i, b_occ); end
        end
        in_valid = 1'b0;
        tick();
        n_assert += 2;
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL stream_drain_occ got %0d want 0", a_occ); end
        if (a_out_ctrl !== 5'h0) begin n_fail++; $display("FAIL stream_drain_ctrl got %0h want 0", a_out_ctrl); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; in_ctrl = 5'h1;
        tick();
        in_data = 32'hB; in_ctrl = 5'h2;
        tick();
        in_valid = 1'b0;
        n_assert += 4;
        if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full got %0d want 2", a_occ); end
        if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0", a_in_ready); end
        if (a_out_data !== 32'hA) begin n_fail++; $display("FAIL bp_head_data got %0h want a", a_out_data); end
        if (a_out_ctrl !== 5'h1) begin n_fail++; $display("FAIL bp_head_ctrl got %0h want 1", a_out_ctrl); end
        tick();
        n_assert += 2;
        if (a_out_data !== 32'hA) begin n_fail++; $display("FAIL bp_stall_data got %0h want a", a_out_data); end
        if (a_out_ctrl !== 5'h1) begin n_fail++; $display("FAIL bp_stall_ctrl got %0h want 1", a_out_ctrl); end
        in_valid = 1'b1; in_data = 32'hC; in_ctrl = 5'h3; out_ready = 1'b1;
        #1;
        n_assert++;
        if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_offer_ready got %0b want 0", a_in_ready); end
        tick();
        in_valid = 1'b0;
        n_assert += 3;
        if (a_out_data !== 32'hB) begin n_fail++; $display("FAIL bp_second_data got %0h want b", a_out_data); end
        if (a_out_ctrl !== 5'h2) begin n_fail++; $display("FAIL bp_second_ctrl got %0h want 2", a_out_ctrl); end
        if (a_occ !== 2'd1) begin n_fail++; $display("FAIL bp_second_occ got %0d want 1", a_occ); end
        tick();
        n_assert += 2;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_c_not_taken got valid %0b data %0h want 0", a_out_valid, a_out_data); end
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL bp_end_occ got %0d want 0", a_occ); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h10; in_ctrl = 5'h4;
        tick();
        in_data = 32'h11; in_ctrl = 5'h5;
        tick();
        n_assert++;
        if (a_occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", a_occ); end
        flush = 1'b1; in_data = 32'hD; in_ctrl = 5'h1F;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_assert += 4;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %0b want 0", a_out_valid); end
        if (a_out_ctrl !== 5'h0) begin n_fail++; $display("FAIL flush_out_ctrl got %0h want 0", a_out_ctrl); end
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", a_occ); end
        if (a_out_data !== 32'h10) begin n_fail++; $display("FAIL flush_data_hold got %0h want 10", a_out_data); end
        tick();
        n_assert += 2;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_d_absent got valid %0b want 0", a_out_valid); end
        if (a_out_data === 32'hD) begin n_fail++; $display("FAIL flush_d_data got %0h want not d", a_out_data); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; in_ctrl = 5'h5;
        tick();
        in_data = 32'h6; in_ctrl = 5'h6; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_assert += 3;
        if (a_out_data !== 32'h6) begin n_fail++; $display("FAIL b2b_data got %0h want 6", a_out_data); end
        if (a_out_ctrl !== 5'h6) begin n_fail++; $display("FAIL b2b_ctrl got %0h want 6", a_out_ctrl); end
        if (a_occ !== 2'd1) begin n_fail++; $display("FAIL b2b_occ got %0d want 1", a_occ); end
        tick();
        n_assert++;
        if (a_occ !== 2'd0) begin n_fail++; $display("FAIL b2b_drain_occ got %0d want 0", a_occ); end
    endtask

    task automatic test_comb_ready();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h21; in_ctrl = 5'h9;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_assert += 3;
        if (b_occ !== 2'd1) begin n_fail++; $display("FAIL comb_occ got %0d want 1", b_occ); end
        if (b_out_data !== 32'h21) begin n_fail++; $display("FAIL comb_data got %0h want 21", b_out_data); end
        if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL comb_ready_stall got %0b want 0", b_in_ready); end
        in_valid = 1'b1; in_data = 32'h22; in_ctrl = 5'hA;
        tick();
        n_assert += 2;
        if (b_occ !== 2'd1) begin n_fail++; $display("FAIL comb_occ_cap got %0d want 1", b_occ); end
        if (b_out_data !== 32'h21) begin n_fail++; $display("FAIL comb_hold_data got %0h want 21", b_out_data); end
        out_ready = 1'b1;
        #1;
        n_assert++;
        if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL comb_ready_go got %0b want 1", b_in_ready); end
        tick();
        n_assert++;
        if (b_out_data !== 32'h22) begin n_fail++; $display("FAIL comb_pass_data got %0h want 22", b_out_data); end
        in_data = 32'h23; reset = 1'b0;
        tick();
        reset = 1'b1; in_valid = 1'b0;
        n_assert += 3;
        if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL comb_rst_valid got %0b want 0", b_out_valid); end
        if (b_occ !== 2'd0) begin n_fail++; $display("FAIL comb_rst_occ got %0d want 0", b_occ); end
        if (b_out_data !== 32'h0) begin n_fail++; $display("FAIL comb_rst_data got %0h want 0", b_out_data); end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_back_to_back();
        test_comb_ready();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
